// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// clocks-per-bit legality rule used by both the receiver and transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int MIN_CLKS_PER_BIT = 8;

  typedef enum logic [2:0] {
    sIDLE,
    sSTART,
    sDATA,
    sPARITY,
    sSTOP,
    sDONE,
    sBRK_WAIT
  } rxState_t;

  // Three samples around mid-bit need enough clocks per bit to stay clear of edges.
  function automatic bit clksPerBitOk(input int clksPerBit);
    return clksPerBit >= MIN_CLKS_PER_BIT;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser plus three-sample majority vote taken around mid-bit,
// timed by the bit counter owned by the receiver FSM.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CW           = $clog2(CLKS_PER_BIT) + 1
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iRxSerial,
  input  logic          iSampleEn,
  input  logic [CW-1:0] iCnt,
  output logic          oRxS,
  output logic          oBit,
  output logic          oBitValid
);

  localparam int M = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_S0  = CW'(M - 1);
  localparam logic [CW-1:0] CNT_S1  = CW'(M);
  localparam logic [CW-1:0] CNT_DEC = CW'(M + 1);

  logic syncMeta;
  logic syncOut;
  logic samp0;
  logic samp1;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      syncMeta <= 1'b1;
      syncOut  <= 1'b1;
    end else begin
      syncMeta <= iRxSerial;
      syncOut  <= syncMeta;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      samp0 <= 1'b1;
      samp1 <= 1'b1;
    end else begin
      if (iSampleEn && (iCnt == CNT_S0)) samp0 <= syncOut;
      if (iSampleEn && (iCnt == CNT_S1)) samp1 <= syncOut;
    end
  end

  // The third sample is the live synchronised line at the decision count.
  assign oRxS      = syncOut;
  assign oBit      = (samp0 & samp1) | (samp0 & syncOut) | (samp1 & syncOut);
  assign oBitValid = iSampleEn && (iCnt == CNT_DEC);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS data, optional odd/even parity,
// one or two stop bits, with framing, parity and break reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iRxSerial,
  output logic [DATA_BITS-1:0] oRxData,
  output logic                 oRxValid,
  output logic                 oParityErr,
  output logic                 oFrameErr,
  output logic                 oBreak,
  output logic                 oBusy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_DATA_END  = IW'(DATA_BITS);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

  if (!clksPerBitOk(CLKS_PER_BIT)) begin : gBadClksPerBit
    $error("uart_rx_cfg: CLKS_PER_BIT must be at least 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : gBadDataBits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if ((PARITY < PAR_NONE) || (PARITY > PAR_EVEN)) begin : gBadParity
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : gBadStopBits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  rxState_t state;
  rxState_t stateNext;

  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shReg;
  logic                 parAcc;
  logic                 anyOne;
  logic                 frmErr;

  logic rxS;
  logic bitVal;
  logic bitValid;
  logic sampleEn;
  logic cntWrap;
  logic parErr;
  logic doneFe;
  logic doneBrk;

  assign sampleEn = (state == sSTART) || (state == sDATA) ||
                    (state == sPARITY) || (state == sSTOP);
  assign cntWrap  = (cnt == CNT_LAST);
  assign oBusy    = (state != sIDLE);

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CW          (CW)
  ) uSampler (
    .iClk     (iClk),
    .iRst     (iRst),
    .iRxSerial(iRxSerial),
    .iSampleEn(sampleEn),
    .iCnt     (cnt),
    .oRxS     (rxS),
    .oBit     (bitVal),
    .oBitValid(bitValid)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= sIDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      sIDLE:     if (!rxS) stateNext = sSTART;
      sSTART: begin
        if (bitValid && bitVal) stateNext = sIDLE;
        else if (cntWrap)       stateNext = sDATA;
      end
      sDATA: begin
        if (cntWrap && (idx == IDX_DATA_END))
          stateNext = (PARITY != PAR_NONE) ? sPARITY : sSTOP;
      end
      sPARITY:   if (cntWrap) stateNext = sSTOP;
      // Leave at the final stop decision to gain half a bit of resync margin.
      sSTOP:     if (bitValid && (idx == IDX_STOP_LAST)) stateNext = sDONE;
      sDONE:     stateNext = oBreak ? sBRK_WAIT : sIDLE;
      sBRK_WAIT: if (rxS && cntWrap) stateNext = sIDLE;
      default:   stateNext = sIDLE;
    endcase
  end

  always_comb begin
    parErr = 1'b0;
    if (PARITY == PAR_ODD)       parErr = ~parAcc;
    else if (PARITY == PAR_EVEN) parErr = parAcc;
  end

  assign doneFe  = frmErr | ~bitVal;
  assign doneBrk = ~anyOne & doneFe;

  // In BRK_WAIT the counter measures consecutive high cycles instead of bit time.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt <= '0;
    end else begin
      case (state)
        sSTART, sDATA, sPARITY, sSTOP: cnt <= cntWrap ? '0 : cnt + 1'b1;
        sBRK_WAIT:                     cnt <= rxS ? cnt + 1'b1 : '0;
        default:                       cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      idx        <= '0;
      shReg      <= '0;
      parAcc     <= 1'b0;
      anyOne     <= 1'b0;
      frmErr     <= 1'b0;
      oRxData    <= '0;
      oRxValid   <= 1'b0;
      oParityErr <= 1'b0;
      oFrameErr  <= 1'b0;
      oBreak     <= 1'b0;
    end else begin
      oRxValid <= 1'b0;
      case (state)
        sIDLE: begin
          idx    <= '0;
          parAcc <= 1'b0;
          anyOne <= 1'b0;
          frmErr <= 1'b0;
        end
        sDATA: begin
          if (bitValid) begin
            shReg  <= {bitVal, shReg[DATA_BITS-1:1]};
            idx    <= idx + 1'b1;
            parAcc <= parAcc ^ bitVal;
            anyOne <= anyOne | bitVal;
          end else if (cntWrap && (idx == IDX_DATA_END)) begin
            idx <= '0;
          end
        end
        sPARITY: begin
          if (bitValid) begin
            parAcc <= parAcc ^ bitVal;
            anyOne <= anyOne | bitVal;
          end
        end
        sSTOP: begin
          if (bitValid) begin
            idx <= idx + 1'b1;
            if (!bitVal) frmErr <= 1'b1;
            if (idx == IDX_STOP_LAST) begin
              oRxValid   <= 1'b1;
              oRxData    <= doneBrk ? '0 : shReg;
              oParityErr <= parErr;
              oFrameErr  <= doneFe;
              oBreak     <= doneBrk;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16 clocks/bit.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic rx2 = 1'b1;

  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic v0, p0, f0, b0, busy0;
  logic v1, p1, f1, b1, busy1;
  logic v2, p2, f2, b2, busy2;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8n1 (
    .iClk(clk), .iRst(rst), .iRxSerial(rx0), .oRxData(d0), .oRxValid(v0),
    .oParityErr(p0), .oFrameErr(f0), .oBreak(b0), .oBusy(busy0)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u7e1 (
    .iClk(clk), .iRst(rst), .iRxSerial(rx1), .oRxData(d1), .oRxValid(v1),
    .oParityErr(p1), .oFrameErr(f1), .oBreak(b1), .oBusy(busy1)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u8n2 (
    .iClk(clk), .iRst(rst), .iRxSerial(rx2), .oRxData(d2), .oRxValid(v2),
    .oParityErr(p2), .oFrameErr(f2), .oBreak(b2), .oBusy(busy2)
  );

  // scoreboard: every valid pulse records {break, frame, parity, data}
  int checks   = 0;
  int failures = 0;
  logic [11:0] obs0[$];
  logic [11:0] obs1[$];
  logic [11:0] obs2[$];

  always @(negedge clk) begin
    if (v0) obs0.push_back({b0, f0, p0, 1'b0, d0});
    if (v1) obs1.push_back({b1, f1, p1, 2'b00, d1});
    if (v2) obs2.push_back({b2, f2, p2, 1'b0, d2});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_frame(input int line, input string tag, input logic [11:0] exp);
    logic [11:0] got;
    got = 12'hfff;
    case (line)
      0:       if (obs0.size() > 0) got = obs0.pop_front();
      1:       if (obs1.size() > 0) got = obs1.pop_front();
      default: if (obs2.size() > 0) got = obs2.pop_front();
    endcase
    check(tag, 32'(got), 32'(exp));
  endtask

  // driver
  task automatic set_line(input int line, input logic v);
    case (line)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Drives n bits LSB first, one bit per CPB clocks, changing only on negedges.
  // Cycle gofs of bit gbit is inverted to model a glitch; the line idles high after.
  task automatic send(input int line, input logic [15:0] bits, input int n,
                      input int gbit, input int gofs);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < CPB; j++) begin
        set_line(line, (i == gbit && j == gofs) ? ~bits[i] : bits[i]);
        @(negedge clk);
      end
    end
    set_line(line, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data0", 32'(d0), 32'h0);
    check("rst_flags0", 32'({v0, p0, f0, b0, busy0}), 32'h0);
    check("rst_data1", 32'(d1), 32'h0);
    check("rst_busy2", 32'(busy2), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 back-to-back frames
    send(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10, -1, 0);
    send(0, {6'h3f, 1'b1, 8'h3C, 1'b0}, 10, -1, 0);
    repeat (4) @(negedge clk);
    check("t1_count", 32'(obs0.size()), 32'd2);
    expect_frame(0, "t1_a5", {3'b000, 9'h0A5});
    expect_frame(0, "t1_3c", {3'b000, 9'h03C});
    check("t1_hold", 32'(d0), 32'h3C);
    check("t1_valid_low", 32'(v0), 32'h0);
    check("t1_idle", 32'(busy0), 32'h0);

    // 7E1: 0x55 has four ones, so a correct even parity bit is 0
    send(1, {6'h3f, 1'b1, 1'b1, 7'h55, 1'b0}, 10, -1, 0);
    send(1, {6'h3f, 1'b1, 1'b0, 7'h55, 1'b0}, 10, -1, 0);
    repeat (4) @(negedge clk);
    check("t2_count", 32'(obs1.size()), 32'd2);
    expect_frame(1, "t2_bad_parity", {3'b001, 9'h055});
    expect_frame(1, "t2_good_parity", {3'b000, 9'h055});

    // 8N2 with the second stop bit low
    send(2, {5'h1f, 1'b0, 1'b1, 8'h81, 1'b0}, 11, -1, 0);
    repeat (40) @(negedge clk);
    check("t3_count", 32'(obs2.size()), 32'd1);
    expect_frame(2, "t3_frame_err", {3'b010, 9'h081});
    check("t3_idle", 32'(busy2), 32'h0);

    // false start: line low for 5 cycles
    set_line(0, 1'b0);
    repeat (4) @(negedge clk);
    check("t4_busy_start", 32'(busy0), 32'h1);
    @(negedge clk);
    set_line(0, 1'b1);
    repeat (9) @(negedge clk);
    check("t4_busy_release", 32'(busy0), 32'h0);
    repeat (40) @(negedge clk);
    check("t4_no_valid", 32'(obs0.size()), 32'd0);

    // one-cycle low glitch on the middle sample of data bit 3
    send(0, {6'h3f, 1'b1, 8'hFF, 1'b0}, 10, 4, 9);
    repeat (4) @(negedge clk);
    check("t4_glitch_count", 32'(obs0.size()), 32'd1);
    expect_frame(0, "t4_glitch", {3'b000, 9'h0FF});

    // break: 12 bit times low
    send(0, 16'h0000, 12, -1, 0);
    check("t5_count", 32'(obs0.size()), 32'd1);
    expect_frame(0, "t5_break", {3'b110, 9'h000});
    check("t5_brk_wait", 32'(busy0), 32'h1);
    repeat (10) @(negedge clk);
    check("t5_brk_hold", 32'(busy0), 32'h1);
    repeat (14) @(negedge clk);
    check("t5_brk_release", 32'(busy0), 32'h0);
    check("t5_no_extra", 32'(obs0.size()), 32'd0);
    send(0, {6'h3f, 1'b1, 8'h12, 1'b0}, 10, -1, 0);
    repeat (4) @(negedge clk);
    expect_frame(0, "t5_after_break", {3'b000, 9'h012});
    check("t5_break_cleared", 32'({b0, f0}), 32'h0);

    // reset pulse in the middle of data bit 4
    fork
      send(0, {6'h3f, 1'b1, 8'hF5, 1'b0}, 10, -1, 0);
      begin
        repeat (CPB * 5 + 8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_data", 32'(d0), 32'h0);
        check("t6_rst_busy", 32'(busy0), 32'h0);
        check("t6_rst_flags", 32'({v0, p0, f0, b0}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("t6_no_valid", 32'(obs0.size()), 32'd0);
    send(0, {6'h3f, 1'b1, 8'h7E, 1'b0}, 10, -1, 0);
    repeat (4) @(negedge clk);
    check("t6_count", 32'(obs0.size()), 32'd1);
    expect_frame(0, "t6_7e", {3'b000, 9'h07E});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver. Data width, parity mode and stop-bit count are configurable. Each bit is decided by a 3-sample majority vote. The block rejects false starts, flags parity errors, framing errors and line breaks, and presents each received word with a one-cycle valid strobe to the downstream command/arith front end.

Parameters:
CLK_FREQ, 125_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line baud rate
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE, clocks per bit; must be >= 8 (elaboration-time check)
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
iClk  in  1  system clock
iRst  in  1  asynchronous active-high reset
iRxSerial  in  1  asynchronous serial line; idles high
oRxData  out  DATA_BITS  last received word, LSB = first data bit on line
oRxValid  out  1  one-cycle pulse; oRxData and error flags are updated in the same cycle
oParityErr  out  1  parity mismatch in the last frame (always 0 when PARITY = 0)
oFrameErr  out  1  any stop bit sampled low in the last frame
oBreak  out  1  last frame was a break condition
oBusy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-high. Every state register clears immediately, including mid-frame. The partial frame is discarded, with no oRxValid pulse.
- Reset values: synchroniser flops = 1, state = IDLE, counters = 0, oRxData = 0, all flags = 0, oRxValid = 0, oBusy = 0.
- Input path: two-flop synchroniser, then the synchronised signal rS.
- Bit timing: per-bit counter runs 0..CLKS_PER_BIT-1. Let M = CLKS_PER_BIT/2. rS is sampled at counts M-1, M and M+1. The bit value is the majority of the three samples and is decided at count M+1.
- IDLE: when rS = 0, go to START with counter = 0.
- START: at the decision point, if the voted bit = 1 (false start or glitch), return to IDLE. Otherwise go to DATA when the counter wraps.
- DATA: shift in DATA_BITS voted bits, LSB first. After the last bit, go to PARITY if PARITY != 0, else to STOP.
- PARITY: take one voted bit. Error if the XOR of data bits and parity bit is not 1 (odd mode) or not 0 (even mode).
- STOP: take STOP_BITS voted bits; any 0 sets the frame error. At the decision point of the final stop bit, go to DONE immediately without waiting for the bit to end. This gives half a bit of resync margin for back-to-back frames.
- DONE, held for exactly 1 cycle:
  - pulse oRxValid;
  - register oRxData, oParityErr, oFrameErr and oBreak;
  - next state is BRK_WAIT if break, else IDLE.
- Break condition: all data bits = 0, parity bit (if present) = 0 and frame error set. oBreak = 1 and oRxData = 0. oParityErr is reported normally.
- BRK_WAIT: stay until rS has been high for CLKS_PER_BIT consecutive cycles, then go to IDLE. No start detection occurs while in BRK_WAIT.
- Outputs oRxData and the flags hold their values until the next DONE. oRxValid is 0 in all other cycles.
- Latency: oRxValid rises (1 + DATA_BITS + P + STOP_BITS - 1) * CLKS_PER_BIT + M + 2 cycles after rS falls, where P = 1 if PARITY != 0.
- Counter width: $clog2(CLKS_PER_BIT) + 1. Bit index width: $clog2(DATA_BITS + 1).

Decomposition:
- Package uart_pkg:
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - state encodings sIDLE, sSTART, sDATA, sPARITY, sSTOP, sDONE, sBRK_WAIT;
  - a shared CLKS_PER_BIT legality check, reused by the future uart_tx_cfg.
- Sub-module uart_rx_sampler contains:
  - the two-flop synchroniser;
  - 3-sample capture at M-1, M, M+1 relative to an external counter;
  - the majority vote.
  - Outputs: rS and a voted-bit-valid strobe. Same iClk/iRst.

Test Plan:
All scenarios use CLKS_PER_BIT = 16.
1. 8N1, send 0xA5 then 0x3C back-to-back with 1 stop bit -> two oRxValid pulses; oRxData = 0xA5 then 0x3C; all flags 0.
2. DATA_BITS = 7, PARITY = 2 (even), send 0x55 with parity bit = 1 (wrong) -> oRxValid; oRxData = 0x55; oParityErr = 1; oFrameErr = 0. Repeat with parity bit = 0 -> oParityErr = 0.
3. 8N2, send 0x81 with second stop bit driven low -> oRxValid; oRxData = 0x81; oFrameErr = 1.
4. Line low for 5 cycles, then high -> no oRxValid; oBusy returns to 0 by cycle M+2 after the falling edge. Separately, a 1-cycle low glitch centred on count M of data bit 3 in a 0xFF frame -> oRxData = 0xFF (majority rejects the glitch).
5. Line held low for 12 bit times, then high -> exactly one oRxValid with oBreak = 1, oFrameErr = 1, oRxData = 0x00. No further frame until the line has been high for 16 cycles. A following 0x12 is then received correctly.
6. Assert iRst for 1 cycle during data bit 4 of a frame -> all outputs return to reset values immediately; no oRxValid for that frame. The next full frame 0x7E is received correctly.
